// File: rtl/fwd_hazard_unit.sv
// Per-operand EX forwarding selects plus load-use bubble and multiply stall control.
// Optional build macro HAZ_STALL_STATS_EN adds saturating stall-cycle counters.
module fwd_hazard_unit #(
   parameter int REG_AW  = 4,
   parameter int NSRC    = 2,
   parameter int MUL_LAT = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     id_valid,
   input  logic [NSRC*REG_AW-1:0]   id_rs,
   input  logic [NSRC*REG_AW-1:0]   idex_rs,
   input  logic [REG_AW-1:0]        idex_rd,
   input  logic                     idex_rw,
   input  logic                     idex_load,
   input  logic [REG_AW-1:0]        exmem_rd,
   input  logic                     exmem_rw,
   input  logic [REG_AW-1:0]        memwb_rd,
   input  logic                     memwb_rw,
   input  logic                     ex_mul_start,
   output logic [2*NSRC-1:0]        fwd_sel,
   output logic                     stall_if,
   output logic                     stall_id,
   output logic                     flush_ex,
`ifdef HAZ_STALL_STATS_EN
   output logic [15:0]              lu_stall_cnt,
   output logic [15:0]              mul_stall_cnt,
`endif
   output logic                     mul_busy
);

   localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [MCW-1:0] MCNT_LOAD = MCW'(MUL_LAT - 2);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LU_BUBBLE = 2'd1,
      MUL_WAIT  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [MCW-1:0]   mcnt_r;
   logic [MCW-1:0]   mcnt_nxt_s;
   logic             lu_mask_r;
   logic             rs_match_s;
   logic             lu_hit_s;

   // Forward select per EX operand; EX/MEM beats MEM/WB and r0 is never forwarded
   always_comb begin
      fwd_sel = {(2*NSRC){1'b0}};
      for (int k = 0; k < NSRC; k++) begin
         if (exmem_rw && (exmem_rd != {REG_AW{1'b0}}) &&
             (exmem_rd == idex_rs[k*REG_AW +: REG_AW])) begin
            fwd_sel[2*k +: 2] = 2'b10;
         end else if (memwb_rw && (memwb_rd != {REG_AW{1'b0}}) &&
                      (memwb_rd == idex_rs[k*REG_AW +: REG_AW])) begin
            fwd_sel[2*k +: 2] = 2'b01;
         end else begin
            fwd_sel[2*k +: 2] = 2'b00;
         end
      end
   end

   // Load-use detect; gating on id_valid keeps garbage id_rs from raising a hit
   always_comb begin
      rs_match_s = 1'b0;
      lu_hit_s   = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         if (id_rs[k*REG_AW +: REG_AW] == idex_rd) begin
            rs_match_s = 1'b1;
         end else begin
            rs_match_s = rs_match_s;
         end
      end
      if (id_valid && idex_load && idex_rw && (idex_rd != {REG_AW{1'b0}})) begin
         lu_hit_s = rs_match_s;
      end else begin
         lu_hit_s = 1'b0;
      end
   end

   // Next-state and multiply counter decisions
   always_comb begin
      state_nxt_s = state_r;
      mcnt_nxt_s  = mcnt_r;
      case (state_r)
         IDLE: begin
            if (ex_mul_start) begin
               state_nxt_s = MUL_WAIT;
               mcnt_nxt_s  = MCNT_LOAD;
            end else if (lu_hit_s && !lu_mask_r) begin
               state_nxt_s = LU_BUBBLE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LU_BUBBLE: begin
            state_nxt_s = IDLE;
         end
         MUL_WAIT: begin
            if (mcnt_r == {MCW{1'b0}}) begin
               state_nxt_s = IDLE;
            end else begin
               mcnt_nxt_s = mcnt_r - MCW'(1);
            end
         end
         default: begin
            state_nxt_s = IDLE;
            mcnt_nxt_s  = {MCW{1'b0}};
         end
      endcase
   end

   // State, counter and stall outputs registered from the next-state decision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         mcnt_r    <= {MCW{1'b0}};
         lu_mask_r <= 1'b0;
         stall_if  <= 1'b0;
         stall_id  <= 1'b0;
         flush_ex  <= 1'b0;
         mul_busy  <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         mcnt_r    <= mcnt_nxt_s;
         // the IDLE cycle right after a bubble must not start another one
         lu_mask_r <= (state_r == LU_BUBBLE);
         stall_if  <= (state_nxt_s != IDLE);
         stall_id  <= (state_nxt_s != IDLE);
         flush_ex  <= (state_nxt_s == LU_BUBBLE);
         mul_busy  <= (state_nxt_s == MUL_WAIT);
      end
   end

`ifdef HAZ_STALL_STATS_EN
   // Saturating counts of cycles spent in each stall state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lu_stall_cnt  <= 16'd0;
         mul_stall_cnt <= 16'd0;
      end else begin
         if ((state_r == LU_BUBBLE) && (lu_stall_cnt != 16'hFFFF)) begin
            lu_stall_cnt <= lu_stall_cnt + 16'd1;
         end
         if ((state_r == MUL_WAIT) && (mul_stall_cnt != 16'hFFFF)) begin
            mul_stall_cnt <= mul_stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed cases plus randomized traffic
// compared every cycle against a countdown-based behavioural model.
module tb_fwd_hazard_unit;
   localparam int REG_AW  = 4;
   localparam int NSRC    = 2;
   localparam int MUL_LAT = 3;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   id_valid;
   logic [NSRC*REG_AW-1:0] id_rs;
   logic [NSRC*REG_AW-1:0] idex_rs;
   logic [REG_AW-1:0]      idex_rd;
   logic                   idex_rw;
   logic                   idex_load;
   logic [REG_AW-1:0]      exmem_rd;
   logic                   exmem_rw;
   logic [REG_AW-1:0]      memwb_rd;
   logic                   memwb_rw;
   logic                   ex_mul_start;
   logic [2*NSRC-1:0]      fwd_sel;
   logic                   stall_if;
   logic                   stall_id;
   logic                   flush_ex;
   logic                   mul_busy;
`ifdef HAZ_STALL_STATS_EN
   logic [15:0]            lu_stall_cnt;
   logic [15:0]            mul_stall_cnt;
   int                     m_lu_cnt;
   int                     m_mul_cnt;
`endif

   int   checks = 0;
   int   errors = 0;
   // model: remaining busy cycles, remaining bubble cycles, hit-mask for this cycle
   int   m_busy;
   int   m_bub;
   logic m_mask;

   fwd_hazard_unit #(.REG_AW(REG_AW), .NSRC(NSRC), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
      .idex_rs(idex_rs), .idex_rd(idex_rd), .idex_rw(idex_rw), .idex_load(idex_load),
      .exmem_rd(exmem_rd), .exmem_rw(exmem_rw), .memwb_rd(memwb_rd), .memwb_rw(memwb_rw),
      .ex_mul_start(ex_mul_start), .fwd_sel(fwd_sel), .stall_if(stall_if),
      .stall_id(stall_id), .flush_ex(flush_ex),
`ifdef HAZ_STALL_STATS_EN
      .lu_stall_cnt(lu_stall_cnt), .mul_stall_cnt(mul_stall_cnt),
`endif
      .mul_busy(mul_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*NSRC-1:0] model_fwd();
      logic [2*NSRC-1:0] r;
      logic [REG_AW-1:0] src;
      r = '0;
      for (int k = 0; k < NSRC; k++) begin
         src = idex_rs[k*REG_AW +: REG_AW];
         if (exmem_rw && exmem_rd != 0 && exmem_rd == src) r[2*k +: 2] = 2'b10;
         else if (memwb_rw && memwb_rd != 0 && memwb_rd == src) r[2*k +: 2] = 2'b01;
      end
      return r;
   endfunction

   function automatic logic model_hit();
      logic any;
      any = 1'b0;
      for (int k = 0; k < NSRC; k++)
         if (id_rs[k*REG_AW +: REG_AW] == idex_rd) any = 1'b1;
      return id_valid && idex_load && idex_rw && (idex_rd != 0) && any;
   endfunction

   task automatic model_reset();
      m_busy = 0;
      m_bub  = 0;
      m_mask = 1'b0;
`ifdef HAZ_STALL_STATS_EN
      m_lu_cnt  = 0;
      m_mul_cnt = 0;
`endif
   endtask

   task automatic model_step();
      logic new_mask;
      if (!rst_n) begin
         model_reset();
         return;
      end
`ifdef HAZ_STALL_STATS_EN
      if (m_bub > 0 && m_lu_cnt < 65535) m_lu_cnt++;
      if (m_busy > 0 && m_mul_cnt < 65535) m_mul_cnt++;
`endif
      new_mask = (m_bub > 0);
      if (m_busy == 0 && m_bub == 0) begin
         if (ex_mul_start) m_busy = MUL_LAT - 1;
         else if (model_hit() && !m_mask) m_bub = 1;
      end else begin
         if (m_busy > 0) m_busy--;
         if (m_bub > 0) m_bub--;
      end
      m_mask = new_mask;
   endtask

   task automatic compare_model();
      check("fwd_sel", 32'(fwd_sel), 32'(model_fwd()));
      check("stall_if", 32'(stall_if), 32'((m_busy > 0) || (m_bub > 0)));
      check("stall_id", 32'(stall_id), 32'((m_busy > 0) || (m_bub > 0)));
      check("flush_ex", 32'(flush_ex), 32'(m_bub > 0));
      check("mul_busy", 32'(mul_busy), 32'(m_busy > 0));
`ifdef HAZ_STALL_STATS_EN
      check("lu_stall_cnt", 32'(lu_stall_cnt), 32'(m_lu_cnt));
      check("mul_stall_cnt", 32'(mul_stall_cnt), 32'(m_mul_cnt));
`endif
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_model();
   endtask

   task automatic idle_inputs();
      id_valid = 1'b0; id_rs = '0; idex_rs = '0; idex_rd = '0; idex_rw = 1'b0;
      idex_load = 1'b0; exmem_rd = '0; exmem_rw = 1'b0; memwb_rd = '0;
      memwb_rw = 1'b0; ex_mul_start = 1'b0;
   endtask

   task automatic set_lu_hit();
      id_valid = 1'b1; idex_load = 1'b1; idex_rw = 1'b1; idex_rd = 4'd7;
      id_rs = {4'd2, 4'd7};
   endtask

   task automatic check_stalls(input string name, input logic e_if, input logic e_fl,
                               input logic e_busy);
      check({name, ".stall_if"}, 32'(stall_if), 32'(e_if));
      check({name, ".stall_id"}, 32'(stall_id), 32'(e_if));
      check({name, ".flush_ex"}, 32'(flush_ex), 32'(e_fl));
      check({name, ".mul_busy"}, 32'(mul_busy), 32'(e_busy));
   endtask

   task automatic rand_inputs();
      id_valid  = ($urandom_range(0, 3) != 0);
      idex_rd   = REG_AW'($urandom_range(0, 3));
      idex_rw   = ($urandom_range(0, 3) != 0);
      idex_load = ($urandom_range(0, 1) != 0);
      exmem_rd  = REG_AW'($urandom_range(0, 3));
      exmem_rw  = ($urandom_range(0, 1) != 0);
      memwb_rd  = REG_AW'($urandom_range(0, 3));
      memwb_rw  = ($urandom_range(0, 1) != 0);
      ex_mul_start = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < NSRC; k++) begin
         id_rs[k*REG_AW +: REG_AW]   = REG_AW'($urandom_range(0, 3));
         idex_rs[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
      end
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_stalls("reset", 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      cycle();

      // forwarding priority and r0 exclusion
      idex_rs = {4'd3, 4'd5};
      exmem_rd = 4'd5; exmem_rw = 1'b1; memwb_rd = 4'd5; memwb_rw = 1'b1;
      #1 check("fwd_both_match", 32'(fwd_sel), 32'h2);
      exmem_rw = 1'b0;
      #1 check("fwd_memwb_only", 32'(fwd_sel), 32'h1);
      memwb_rd = 4'd3;
      #1 check("fwd_memwb_op1", 32'(fwd_sel), 32'h4);
      exmem_rd = 4'd3; exmem_rw = 1'b1; memwb_rd = 4'd5;
      #1 check("fwd_split", 32'(fwd_sel), 32'h9);
      idex_rs = '0; exmem_rd = 4'd0; memwb_rd = 4'd0;
      #1 check("fwd_r0", 32'(fwd_sel), 32'h0);
      idle_inputs();
      cycle();

      // load-use held for three cycles gives exactly one bubble
      set_lu_hit();
      cycle(); check_stalls("lu_c1", 1'b1, 1'b1, 1'b0);
      cycle(); check_stalls("lu_c2", 1'b0, 1'b0, 1'b0);
      cycle(); check_stalls("lu_c3", 1'b0, 1'b0, 1'b0);
      idle_inputs();
      cycle(); check_stalls("lu_c4", 1'b0, 1'b0, 1'b0);

      // id_valid low suppresses the hit
      set_lu_hit(); id_valid = 1'b0;
      cycle(); check_stalls("lu_invalid", 1'b0, 1'b0, 1'b0);
      idle_inputs();

      // multiply: MUL_LAT-1 busy cycles, hit during MUL_WAIT ignored
      ex_mul_start = 1'b1;
      cycle(); check_stalls("mul_c1", 1'b1, 1'b0, 1'b1);
      ex_mul_start = 1'b0; set_lu_hit();
      cycle(); check_stalls("mul_c2", 1'b1, 1'b0, 1'b1);
      idle_inputs();
      cycle(); check_stalls("mul_c3", 1'b0, 1'b0, 1'b0);
      cycle(); check_stalls("mul_c4", 1'b0, 1'b0, 1'b0);

      // simultaneous start and hit: multiply wins, no flush
      set_lu_hit(); ex_mul_start = 1'b1;
      cycle(); check_stalls("sim_c1", 1'b1, 1'b0, 1'b1);
      idle_inputs();
      cycle(); check_stalls("sim_c2", 1'b1, 1'b0, 1'b1);
      cycle(); check_stalls("sim_c3", 1'b0, 1'b0, 1'b0);

      // asynchronous reset one cycle into MUL_WAIT
      ex_mul_start = 1'b1;
      cycle(); check_stalls("rst_pre", 1'b1, 1'b0, 1'b1);
      ex_mul_start = 1'b0;
      rst_n = 1'b0;
      #1 check_stalls("rst_async", 1'b0, 1'b0, 1'b0);
      model_reset();
      cycle();
      rst_n = 1'b1;
      ex_mul_start = 1'b1;
      cycle(); check_stalls("rst_mul1", 1'b1, 1'b0, 1'b1);
      ex_mul_start = 1'b0;
      cycle(); check_stalls("rst_mul2", 1'b1, 1'b0, 1'b1);
      cycle(); check_stalls("rst_mul3", 1'b0, 1'b0, 1'b0);

      // randomized traffic with occasional resets
      for (int i = 0; i < 4000; i++) begin
         rand_inputs();
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline forwarding logic.
- Generates per-source-operand forward selects for NSRC operands, not just two.
- Adds sequential hazard control: a one-bubble load-use stall, plus a counted stall while a MUL_LAT-cycle multiply is in EX.
- Sits beside the ID/EX register. Drives the EX operand muxes and the IF/ID/EX stall/flush controls.

Parameters:
- REG_AW, 4, register-address width in bits.
- NSRC, 2, source operands per instruction (1..4).
- MUL_LAT, 3, multiply latency in EX cycles (>=2).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous and active-low
- id_valid  in  1  the ID-stage instruction is valid
- id_rs  in  NSRC*REG_AW  ID-stage source addresses; operand k is at [k*REG_AW +: REG_AW]
- idex_rs  in  NSRC*REG_AW  ID/EX source addresses, same packing as id_rs
- idex_rd  in  REG_AW  ID/EX destination
- idex_rw  in  1  ID/EX writes a register
- idex_load  in  1  ID/EX instruction is a load
- exmem_rd  in  REG_AW  EX/MEM destination
- exmem_rw  in  1  EX/MEM writes a register
- memwb_rd  in  REG_AW  MEM/WB destination
- memwb_rw  in  1  MEM/WB writes a register
- ex_mul_start  in  1  a multiply enters EX this cycle
- fwd_sel  out  2*NSRC  per-operand forward select; operand k is at [2k +: 2]
- stall_if  out  1  hold the PC
- stall_id  out  1  hold the IF/ID register
- flush_ex  out  1  insert a bubble into ID/EX
- mul_busy  out  1  a multiply is in progress

Behaviour:
- fwd_sel is combinational, evaluated per operand k, in priority order:
  - 2'b10 if exmem_rw, exmem_rd != 0 and exmem_rd == idex_rs[k].
  - Otherwise 2'b01 if memwb_rw, memwb_rd != 0 and memwb_rd == idex_rs[k].
  - Otherwise 2'b00.
  - Register 0 is never forwarded. EX/MEM wins when both stages match.
- lu_hit (combinational) = id_valid & idex_load & idex_rw & (idex_rd != 0) & (idex_rd == any id_rs[k]).
- FSM states are IDLE, LU_BUBBLE and MUL_WAIT. The counter mcnt is ceil(log2(MUL_LAT)) bits wide.
- IDLE:
  - If ex_mul_start: load mcnt = MUL_LAT-2 and go to MUL_WAIT. ex_mul_start has priority over lu_hit in the same cycle.
  - Else if lu_hit: go to LU_BUBBLE.
  - Outputs in IDLE are registered from the next-state decision. stall_if, stall_id and flush_ex go high in the cycle after the hit is detected, for exactly one cycle.
- LU_BUBBLE:
  - stall_if = 1, stall_id = 1, flush_ex = 1.
  - Next state is always IDLE. A re-evaluated lu_hit may not chain a second bubble in the next cycle; it is masked for one cycle.
- MUL_WAIT:
  - mul_busy = 1, stall_if = 1, stall_id = 1, flush_ex = 0. EX holds, so no bubble is inserted.
  - Each cycle, mcnt decrements. When mcnt == 0, go to IDLE; mul_busy drops the following cycle.
  - Total mul_busy high time = MUL_LAT-1 cycles.
  - lu_hit and ex_mul_start are ignored in this state.
- All registered outputs come from flops; fwd_sel is the only combinational output.
- Reset (asynchronous, rst_n low): state = IDLE, mcnt = 0, stall_if = stall_id = flush_ex = mul_busy = 0. Reset mid-MUL_WAIT or mid-LU_BUBBLE aborts immediately. The first cycle after release is IDLE.
- X-safety: when id_valid = 0, lu_hit = 0 regardless of id_rs.

Optional Feature:
- Macro HAZ_STALL_STATS_EN.
- When defined, two extra outputs are added:
  - lu_stall_cnt [15:0]: counts cycles spent in LU_BUBBLE.
  - mul_stall_cnt [15:0]: counts cycles spent in MUL_WAIT.
  - Both saturate at 16'hFFFF (no wrap) and reset to 0 on rst_n.
- When undefined, the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Operand forwarding priority: NSRC = 2, idex_rs = {4'd3, 4'd5}, exmem_rd = 5 with rw = 1, memwb_rd = 5 with rw = 1, memwb_rd = 3 alternate case -> fwd_sel[1:0] = 2'b10; with exmem_rw = 0 -> 2'b01. Then set exmem_rd = 0 and memwb_rd = 0 with rw = 1 -> 2'b00.
- Load-use bubble: idex_load = 1, idex_rw = 1, idex_rd = 7, id_rs[0] = 7, id_valid = 1, held for 3 cycles -> stall_if, stall_id and flush_ex are high for exactly 1 cycle (the cycle after the hit), then 0.
- Multiply stall: MUL_LAT = 3, pulse ex_mul_start -> mul_busy and stall_if high for 2 cycles, flush_ex = 0 throughout; a lu_hit raised during MUL_WAIT produces no bubble.
- Simultaneous events: ex_mul_start and lu_hit in the same IDLE cycle -> MUL_WAIT is taken and no flush_ex pulse occurs.
- Reset mid-op: assert rst_n = 0 one cycle into MUL_WAIT -> all stall outputs are 0 asynchronously; after release, a fresh ex_mul_start gives the full MUL_LAT-1 busy cycles.
- With HAZ_STALL_STATS_EN: 2 load-use bubbles plus 1 multiply (MUL_LAT = 4) -> lu_stall_cnt = 2, mul_stall_cnt = 3; force 70000 stall cycles -> the counter holds 16'hFFFF.
